hazard_ctrl: RTL and testbench

//   Hazard control unit for the 5-stage MIPS pipeline; the producer of the

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 91 +++++++++
 tb/tb_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX/MEM hazard sources in, stall/flush controls out.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_ctrl_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
);
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_uses_rt;
  logic              id_is_branch;
  logic              id_uses_md;
  logic              br_taken;
  logic              ex_memread;
  logic              ex_regwrite;
  logic [REG_W-1:0]  ex_wreg;
  logic              mem_memread;
  logic [REG_W-1:0]  mem_wreg;
  logic              md_start;
  logic              hold;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, id_uses_md, br_taken,
           ex_memread, ex_regwrite, ex_wreg, mem_memread, mem_wreg, md_start,
    input  hold, idex_bubble, ifid_flush, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, id_uses_md, br_taken,
           ex_memread, ex_regwrite, ex_wreg, mem_memread, mem_wreg, md_start,
    output hold, idex_bubble, ifid_flush, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage MIPS pipeline: load-use, branch-in-ID and mul/div
// busy detection, driving PC/IF-ID hold, ID/EX bubble and IF/ID flush.
module hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_LATENCY = 32,
  parameter int MD_CNT_W   = 6,
  parameter int PERF_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    LD_BR = 1'b1
  } state_t;

  state_t              r_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic                r_md_busy;
  logic [PERF_W-1:0]   r_stall_cnt;

  logic w_ex_match;
  logic w_mem_match;
  logic w_lu;
  logic w_brx;
  logic w_brm;
  logic w_mdh;
  logic w_stall;

  // A nonzero destination equal to a nonzero source is a match; $0 never hazards.
  assign w_ex_match  = (bus.ex_wreg != '0) &&
                       ((bus.ex_wreg == bus.id_rs) ||
                        (bus.id_uses_rt && (bus.ex_wreg == bus.id_rt)));
  assign w_mem_match = (bus.mem_wreg != '0) &&
                       ((bus.mem_wreg == bus.id_rs) ||
                        (bus.id_uses_rt && (bus.mem_wreg == bus.id_rt)));

  assign w_lu  = bus.ex_memread & w_ex_match;
  assign w_brx = bus.id_is_branch & bus.ex_regwrite & ~bus.ex_memread & w_ex_match;
  assign w_brm = bus.id_is_branch & bus.mem_memread & w_mem_match;
  assign w_mdh = bus.id_uses_md & r_md_busy;

  // LD_BR covers the second cycle of a load feeding a branch compare.
  assign w_stall = ~rst & (w_lu | w_brx | w_brm | w_mdh | (r_state == LD_BR));

  assign bus.hold        = w_stall;
  assign bus.idex_bubble = w_stall;
  assign bus.ifid_flush  = ~rst & bus.br_taken & ~w_stall;
  assign bus.md_busy     = r_md_busy;
  assign bus.stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= (w_lu && bus.id_is_branch) ? LD_BR : RUN;
        LD_BR:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Busy for MD_LATENCY cycles: count runs MD_LATENCY-1 down to 0 while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_md_cnt  <= '0;
      r_md_busy <= 1'b0;
    end else if (bus.md_start) begin
      r_md_cnt  <= MD_CNT_W'(MD_LATENCY - 1);
      r_md_busy <= 1'b1;
    end else if (r_md_busy) begin
      if (r_md_cnt == '0) begin
        r_md_busy <= 1'b0;
      end else begin
        r_md_cnt <= r_md_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; inputs change on negedge and
// outputs are checked 1ns later, well away from the sampling posedge.
module tb_hazard_ctrl;
  localparam int REG_W      = 5;
  localparam int MD_LATENCY = 32;
  localparam int MD_CNT_W   = 6;
  localparam int PERF_W     = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hazard_ctrl_if #(.REG_W(REG_W), .PERF_W(PERF_W)) bus ();

  hazard_ctrl #(
    .REG_W(REG_W), .MD_LATENCY(MD_LATENCY), .MD_CNT_W(MD_CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_uses_rt   = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_uses_md   = 1'b0;
    bus.br_taken     = 1'b0;
    bus.ex_memread   = 1'b0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_wreg      = '0;
    bus.mem_memread  = 1'b0;
    bus.mem_wreg     = '0;
    bus.md_start     = 1'b0;
  endtask

  // Advance one clock: through the posedge, back to the next negedge, settle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_wreg = 5'd8; bus.id_rs = 5'd8; bus.br_taken = 1'b1;
    step();
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", bus.hold); end
    n_cmp++; if (bus.idex_bubble !== 1'b0) begin n_bad++; $display("FAIL reset_bubble: got %b want 0", bus.idex_bubble); end
    n_cmp++; if (bus.ifid_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", bus.ifid_flush); end
    n_cmp++; if (bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_md_busy: got %b want 0", bus.md_busy); end
    n_cmp++; if (bus.stall_cnt !== '0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
    clear_inputs();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL reset_release_hold: got %b want 0", bus.hold); end
    $display("test_reset done: cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_load_use();
    logic [PERF_W-1:0] base;
    base = bus.stall_cnt;
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_wreg = 5'd8; bus.id_rs = 5'd8; bus.id_rt = 5'd9;
    #1;
    n_cmp++; if (bus.hold !== 1'b1) begin n_bad++; $display("FAIL lu_hold: got %b want 1", bus.hold); end
    n_cmp++; if (bus.idex_bubble !== 1'b1) begin n_bad++; $display("FAIL lu_bubble: got %b want 1", bus.idex_bubble); end
    step();
    // Load now in MEM, bubble in EX, add still in ID.
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_wreg = '0;
    bus.mem_memread = 1'b1; bus.mem_wreg = 5'd8;
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL lu_second_hold: got %b want 0", bus.hold); end
    n_cmp++; if (bus.stall_cnt !== base + 1) begin n_bad++; $display("FAIL lu_stall_cnt: got %0d want %0d", bus.stall_cnt, base + 1); end
    // rt match only counts when rt is a source.
    clear_inputs();
    bus.ex_memread = 1'b1; bus.ex_wreg = 5'd9; bus.id_rs = 5'd3; bus.id_rt = 5'd9;
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL lu_rt_unused: got %b want 0", bus.hold); end
    bus.id_uses_rt = 1'b1;
    #1;
    n_cmp++; if (bus.hold !== 1'b1) begin n_bad++; $display("FAIL lu_rt_used: got %b want 1", bus.hold); end
    step();
    clear_inputs();
    step();
    $display("test_load_use done: cnt=%0d", bus.stall_cnt);
  endtask

  task automatic test_zero_reg();
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_wreg = '0; bus.id_rs = '0;
    bus.id_is_branch = 1'b1; bus.mem_memread = 1'b1; bus.mem_wreg = '0;
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL zero_reg_hold: got %b want 0", bus.hold); end
    step();
    clear_inputs();
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL zero_reg_after: got %b want 0", bus.hold); end
    step();
    $display("test_zero_reg done");
  endtask

  // realistic=1 moves the load into MEM on the second cycle; 0 leaves only the FSM stall.
  task automatic test_load_branch(input bit realistic);
    logic [PERF_W-1:0] base;
    base = bus.stall_cnt;
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_wreg = 5'd8;
    bus.id_rs = 5'd8; bus.id_rt = 5'd2; bus.id_uses_rt = 1'b1; bus.id_is_branch = 1'b1;
    #1;
    n_cmp++; if (bus.hold !== 1'b1) begin n_bad++; $display("FAIL ldbr_cycle1 (r=%0b): got %b want 1", realistic, bus.hold); end
    step();
    bus.ex_memread = 1'b0; bus.ex_regwrite = 1'b0; bus.ex_wreg = '0;
    bus.mem_memread = realistic; bus.mem_wreg = realistic ? 5'd8 : 5'd0;
    #1;
    n_cmp++; if (bus.hold !== 1'b1) begin n_bad++; $display("FAIL ldbr_cycle2 (r=%0b): got %b want 1", realistic, bus.hold); end
    step();
    bus.mem_memread = 1'b0; bus.mem_wreg = '0;
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL ldbr_cycle3 (r=%0b): got %b want 0", realistic, bus.hold); end
    n_cmp++; if (bus.stall_cnt !== base + 2) begin n_bad++; $display("FAIL ldbr_stall_cnt (r=%0b): got %0d want %0d", realistic, bus.stall_cnt, base + 2); end
    clear_inputs();
    step();
    $display("test_load_branch realistic=%0b done: cnt=%0d", realistic, bus.stall_cnt);
  endtask

  task automatic test_branch_flush();
    bus.id_is_branch = 1'b1; bus.id_rs = 5'd5; bus.id_rt = 5'd6; bus.id_uses_rt = 1'b1; bus.br_taken = 1'b1;
    #1;
    n_cmp++; if (bus.ifid_flush !== 1'b1) begin n_bad++; $display("FAIL flush_taken: got %b want 1", bus.ifid_flush); end
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL flush_taken_hold: got %b want 0", bus.hold); end
    bus.ex_regwrite = 1'b1; bus.ex_wreg = 5'd5;
    #1;
    n_cmp++; if (bus.ifid_flush !== 1'b0) begin n_bad++; $display("FAIL flush_brx: got %b want 0", bus.ifid_flush); end
    n_cmp++; if (bus.hold !== 1'b1) begin n_bad++; $display("FAIL brx_hold: got %b want 1", bus.hold); end
    // Same ALU producer but ID is not a branch: forwarding handles it, no stall.
    bus.id_is_branch = 1'b0; bus.br_taken = 1'b0;
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL brx_nonbranch: got %b want 0", bus.hold); end
    step();
    clear_inputs();
    step();
    $display("test_branch_flush done");
  endtask

  task automatic test_muldiv();
    logic [PERF_W-1:0] base;
    int held;
    bit done;
    base = bus.stall_cnt;
    bus.md_start = 1'b1;
    #1;
    n_cmp++; if (bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL md_busy_issue: got %b want 0", bus.md_busy); end
    step();
    bus.md_start = 1'b0; bus.id_uses_md = 1'b1;
    #1;
    held = 0;
    done = 1'b0;
    for (int i = 0; i < MD_LATENCY + 8 && !done; i++) begin
      if (bus.hold === 1'b1) begin
        held++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL md_timeout: hold still %b after %0d cycles", bus.hold, held); end
    n_cmp++; if (held != MD_LATENCY) begin n_bad++; $display("FAIL md_hold_cycles: got %0d want %0d", held, MD_LATENCY); end
    n_cmp++; if (bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL md_busy_drop: got %b want 0", bus.md_busy); end
    n_cmp++; if (bus.stall_cnt !== base + MD_LATENCY) begin n_bad++; $display("FAIL md_stall_cnt: got %0d want %0d", bus.stall_cnt, base + MD_LATENCY); end
    clear_inputs();
    step();
    $display("test_muldiv done: held=%0d cnt=%0d", held, bus.stall_cnt);
  endtask

  task automatic test_reset_mid();
    bus.md_start = 1'b1;
    step();
    bus.md_start = 1'b0;
    bus.ex_memread = 1'b1; bus.ex_wreg = 5'd8; bus.id_rs = 5'd8; bus.id_is_branch = 1'b1;
    step();
    // Now in LD_BR with the mul/div unit busy.
    clear_inputs();
    bus.id_uses_md = 1'b1; bus.br_taken = 1'b1;
    #1;
    n_cmp++; if (bus.hold !== 1'b1) begin n_bad++; $display("FAIL mid_pre_hold: got %b want 1", bus.hold); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hold: got %b want 0", bus.hold); end
    n_cmp++; if (bus.idex_bubble !== 1'b0) begin n_bad++; $display("FAIL mid_rst_bubble: got %b want 0", bus.idex_bubble); end
    n_cmp++; if (bus.ifid_flush !== 1'b0) begin n_bad++; $display("FAIL mid_rst_flush: got %b want 0", bus.ifid_flush); end
    n_cmp++; if (bus.md_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_md_busy: got %b want 0", bus.md_busy); end
    n_cmp++; if (bus.stall_cnt !== '0) begin n_bad++; $display("FAIL mid_rst_stall_cnt: got %0d want 0", bus.stall_cnt); end
    step();
    clear_inputs();
    bus.id_uses_md = 1'b1; bus.id_rs = 5'd4;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.hold !== 1'b0) begin n_bad++; $display("FAIL mid_release_hold[%0d]: got %b want 0", i, bus.hold); end
    end
    n_cmp++; if (bus.stall_cnt !== '0) begin n_bad++; $display("FAIL mid_release_cnt: got %0d want 0", bus.stall_cnt); end
    clear_inputs();
    $display("test_reset_mid done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_load_branch(1'b1);
    test_load_branch(1'b0);
    test_branch_flush();
    test_muldiv();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
